// File: rtl/sd_host_cmd_pkg.sv
// Shared types and constants for the host-side SD CMD-line engine.
package sd_host_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT,
    ST_RX,
    ST_DONE,
    ST_GAP
  } state_e;

  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_R1   = 2'd1;
  localparam logic [1:0] RSP_R2   = 2'd2;
  localparam logic [1:0] RSP_R3   = 2'd3;

  localparam int FRAME_LEN_SHORT  = 48;
  localparam int FRAME_LEN_LONG   = 136;

  localparam int DEF_TIMEOUT_BITS = 64;
  localparam int DEF_NCC_BITS     = 8;

  localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sd_host_cmd_phy_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first, with synchronous clear and enable.
module sd_crc7
  import sd_host_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic       fb;

  always_comb begin
    fb    = bit_i ^ crc_q[6];
    crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_host_cmd_phy.sv
// Host-side SD CMD engine: 48-bit command TX, 48/136-bit response RX with timeout and frame checks.
// Define SD_HOST_CMD_RSP_CRC_EN to build the RX CRC7 checker; otherwise o_crc_err is tied low.
module sd_host_cmd_phy
  import sd_host_cmd_pkg::*;
#(
  parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS,
  parameter int NCC_BITS     = DEF_NCC_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_bit_stb,
  input  logic         i_cmd_stb,
  input  logic [5:0]   i_cmd_index,
  input  logic [31:0]  i_cmd_arg,
  input  logic [1:0]   i_rsp_type,
  output logic         o_cmd_busy,
  output logic         o_rsp_stb,
  output logic [127:0] o_rsp,
  output logic         o_crc_err,
  output logic         o_frame_err,
  output logic         o_timeout,
  output logic         o_sd_cmd_dir,
  output logic         o_sd_cmd_out,
  input  logic         i_sd_cmd_in
);

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_BITS);
  localparam logic [15:0] NCC_LIM = 16'(NCC_BITS);
  localparam logic [5:0]  TX_END  = 6'(FRAME_LEN_SHORT);

  state_e         state_q;
  logic [39:0]    tx_sreg_q;
  logic [5:0]     tx_cnt_q;
  logic [1:0]     rsp_type_q;
  logic [15:0]    tmo_cnt_q;
  logic [15:0]    ncc_cnt_q;
  logic [7:0]     rx_cnt_q;
  logic [133:0]   rx_sreg_q;
  logic           busy_q, rsp_stb_q, crc_err_q, frame_err_q, timeout_q, dir_q, out_q;
  logic [127:0]   rsp_q;

  logic           accept;
  logic           is_long;
  logic [7:0]     rx_last;
  logic [6:0]     tx_crc;
  logic           tx_crc_en;
  logic           tx_bit;
  logic [127:0]   rsp_d;
  logic           frame_err_d;
  logic           crc_err_d;

  assign accept  = (state_q == ST_IDLE) && i_cmd_stb;
  assign is_long = (rsp_type_q == RSP_R2);
  assign rx_last = is_long ? 8'(FRAME_LEN_LONG - 1) : 8'(FRAME_LEN_SHORT - 1);

  // After the 40 data bits the CRC register keeps clocking with its own MSB as input,
  // which shifts the finished CRC out MSB-first with zero feedback.
  assign tx_crc_en = (state_q == ST_TX) && i_bit_stb && (tx_cnt_q < 6'd47);

  always_comb begin
    tx_bit = 1'b1;
    if (tx_cnt_q < 6'd40) begin
      tx_bit = tx_sreg_q[39];
    end else if (tx_cnt_q < 6'd47) begin
      tx_bit = tx_crc[6];
    end
  end

  sd_crc7 u_tx_crc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (tx_crc_en),
    .bit_i (tx_bit),
    .crc_o (tx_crc)
  );

  // Frame bit j (j >= 1) sits at rx_sreg_q[j-1] when the last bit is on the line.
  assign rsp_d       = is_long ? {rx_sreg_q[126:0], i_sd_cmd_in} : {90'd0, rx_sreg_q[44:7]};
  assign frame_err_d = (is_long ? rx_sreg_q[133] : rx_sreg_q[45]) | ~i_sd_cmd_in;

`ifdef SD_HOST_CMD_RSP_CRC_EN
  logic [6:0] rx_crc;
  logic       rx_crc_en;

  // The start bit is never fed: a leading 0 leaves a cleared CRC unchanged.
  assign rx_crc_en = (state_q == ST_RX) && i_bit_stb &&
                     (is_long ? ((rx_cnt_q >= 8'd8) && (rx_cnt_q < 8'd128))
                              : (rx_cnt_q < 8'd40));

  sd_crc7 u_rx_crc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (rx_crc_en),
    .bit_i (i_sd_cmd_in),
    .crc_o (rx_crc)
  );

  assign crc_err_d = (rsp_type_q != RSP_R3) && (rx_crc != rx_sreg_q[6:0]);
`else
  assign crc_err_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tx_sreg_q   <= '0;
      tx_cnt_q    <= '0;
      rsp_type_q  <= RSP_NONE;
      tmo_cnt_q   <= '0;
      ncc_cnt_q   <= '0;
      rx_cnt_q    <= '0;
      rx_sreg_q   <= '0;
      busy_q      <= 1'b0;
      rsp_stb_q   <= 1'b0;
      rsp_q       <= '0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      dir_q       <= 1'b0;
      out_q       <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_cmd_stb) begin
            state_q     <= ST_TX;
            busy_q      <= 1'b1;
            tx_sreg_q   <= {2'b01, i_cmd_index, i_cmd_arg};
            tx_cnt_q    <= '0;
            rsp_type_q  <= i_rsp_type;
            tmo_cnt_q   <= '0;
            rx_cnt_q    <= '0;
            rx_sreg_q   <= '0;
            rsp_q       <= '0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
          end
        end
        ST_TX: begin
          if (i_bit_stb) begin
            if (tx_cnt_q == TX_END) begin
              dir_q <= 1'b0;
              out_q <= 1'b1;
              if (rsp_type_q == RSP_NONE) begin
                rsp_stb_q <= 1'b1;
                state_q   <= ST_DONE;
              end else if (!i_sd_cmd_in) begin
                rx_cnt_q <= 8'd1;
                state_q  <= ST_RX;
              end else begin
                state_q <= ST_WAIT;
              end
            end else begin
              dir_q     <= 1'b1;
              out_q     <= tx_bit;
              tx_sreg_q <= {tx_sreg_q[38:0], 1'b0};
              tx_cnt_q  <= tx_cnt_q + 6'd1;
            end
          end
        end
        ST_WAIT: begin
          if (i_bit_stb) begin
            if (!i_sd_cmd_in) begin
              rx_cnt_q <= 8'd1;
              state_q  <= ST_RX;
            end else if (tmo_cnt_q + 16'd1 == TMO_LIM) begin
              timeout_q <= 1'b1;
              rsp_stb_q <= 1'b1;
              state_q   <= ST_DONE;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
          end
        end
        ST_RX: begin
          if (i_bit_stb) begin
            rx_sreg_q <= {rx_sreg_q[132:0], i_sd_cmd_in};
            rx_cnt_q  <= rx_cnt_q + 8'd1;
            if (rx_cnt_q == rx_last) begin
              rsp_q       <= rsp_d;
              crc_err_q   <= crc_err_d;
              frame_err_q <= frame_err_d;
              rsp_stb_q   <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          rsp_stb_q <= 1'b0;
          ncc_cnt_q <= '0;
          state_q   <= ST_GAP;
        end
        ST_GAP: begin
          if (i_bit_stb) begin
            if (ncc_cnt_q + 16'd1 == NCC_LIM) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              ncc_cnt_q <= ncc_cnt_q + 16'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_busy   = busy_q;
  assign o_rsp_stb    = rsp_stb_q;
  assign o_rsp        = rsp_q;
  assign o_crc_err    = crc_err_q;
  assign o_frame_err  = frame_err_q;
  assign o_timeout    = timeout_q;
  assign o_sd_cmd_dir = dir_q;
  assign o_sd_cmd_out = out_q;

endmodule

// File: tb/tb_sd_host_cmd_phy.sv
// Directed bench for sd_host_cmd_phy: command framing, response capture, timeout, NCC gap, reset.
module tb_sd_host_cmd_phy;

  localparam int TMO = 64;
  localparam int NCC = 8;

`ifdef SD_HOST_CMD_RSP_CRC_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         i_bit_stb;
  logic         i_cmd_stb;
  logic [5:0]   i_cmd_index;
  logic [31:0]  i_cmd_arg;
  logic [1:0]   i_rsp_type;
  logic         o_cmd_busy;
  logic         o_rsp_stb;
  logic [127:0] o_rsp;
  logic         o_crc_err;
  logic         o_frame_err;
  logic         o_timeout;
  logic         o_sd_cmd_dir;
  logic         o_sd_cmd_out;
  logic         i_sd_cmd_in;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sd_host_cmd_phy #(.TIMEOUT_BITS(TMO), .NCC_BITS(NCC)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_bit_stb    (i_bit_stb),
    .i_cmd_stb    (i_cmd_stb),
    .i_cmd_index  (i_cmd_index),
    .i_cmd_arg    (i_cmd_arg),
    .i_rsp_type   (i_rsp_type),
    .o_cmd_busy   (o_cmd_busy),
    .o_rsp_stb    (o_rsp_stb),
    .o_rsp        (o_rsp),
    .o_crc_err    (o_crc_err),
    .o_frame_err  (o_frame_err),
    .o_timeout    (o_timeout),
    .o_sd_cmd_dir (o_sd_cmd_dir),
    .o_sd_cmd_out (o_sd_cmd_out),
    .i_sd_cmd_in  (i_sd_cmd_in)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference CRC7 over the low n bits of d, MSB first.
  function automatic logic [6:0] crc7_ref(input logic [119:0] d, input int n);
    logic [6:0] c = '0;
    logic       fb;
    for (int i = n - 1; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle, then one strobe cycle; returns #1 after the strobe edge.
  task automatic strobe(input logic line_bit);
    idle_cycle();
    i_sd_cmd_in = line_bit;
    i_bit_stb   = 1'b1;
    @(posedge clk);
    #1;
    i_bit_stb   = 1'b0;
    i_sd_cmd_in = 1'b1;
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ);
    idle_cycle();
    i_cmd_index = idx;
    i_cmd_arg   = arg;
    i_rsp_type  = typ;
    i_cmd_stb   = 1'b1;
    i_bit_stb   = 1'b1;
    @(posedge clk);
    #1;
    i_cmd_stb   = 1'b0;
    i_bit_stb   = 1'b0;
    check_eq("busy_after_accept", o_cmd_busy, 1'b1);
  endtask

  task automatic run_tx(output logic [47:0] line, output int dir_hi);
    line   = '0;
    dir_hi = 0;
    for (int i = 0; i < 48; i++) begin
      strobe(1'b1);
      line = {line[46:0], o_sd_cmd_out};
      if (o_sd_cmd_dir) dir_hi++;
    end
  endtask

  task automatic send_frame(input logic [135:0] f, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) strobe(f[i]);
  endtask

  task automatic check_gap(input string tag);
    int n = 0;
    for (int i = 0; i < 20 && o_cmd_busy; i++) begin
      strobe(1'b1);
      n++;
    end
    check_eq(tag, n, NCC);
  endtask

  task automatic check_rsp(input string tag, input logic [127:0] rsp,
                           input logic crc, input logic frm, input logic tmo);
    check_eq({tag, "_stb"}, o_rsp_stb, 1'b1);
    check_eq({tag, "_rsp"}, o_rsp, rsp);
    check_eq({tag, "_crc"}, o_crc_err, crc);
    check_eq({tag, "_frm"}, o_frame_err, frm);
    check_eq({tag, "_tmo"}, o_timeout, tmo);
  endtask

  logic [47:0]  line;
  int           dir_hi;
  logic [119:0] body;
  logic [135:0] f;
  logic [39:0]  hdr;

  initial begin
    rst = 1'b1; i_bit_stb = 1'b0; i_cmd_stb = 1'b0; i_cmd_index = '0;
    i_cmd_arg = '0; i_rsp_type = '0; i_sd_cmd_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_busy", o_cmd_busy, 1'b0);
    check_eq("rst_stb", o_rsp_stb, 1'b0);
    check_eq("rst_rsp", o_rsp, '0);
    check_eq("rst_errs", {o_crc_err, o_frame_err, o_timeout}, 3'b000);
    check_eq("rst_dir", o_sd_cmd_dir, 1'b0);
    check_eq("rst_out", o_sd_cmd_out, 1'b1);

    // CMD0, no response
    issue(6'd0, 32'h0, 2'd0);
    run_tx(line, dir_hi);
    check_eq("cmd0_line", line, 48'h40_0000_0000_95);
    check_eq("cmd0_dir", dir_hi, 48);
    strobe(1'b1);
    check_eq("cmd0_release", o_sd_cmd_dir, 1'b0);
    check_rsp("cmd0", 128'h0, 1'b0, 1'b0, 1'b0);
    check_gap("cmd0_ncc");
    check_eq("cmd0_stb_low", o_rsp_stb, 1'b0);

    // CMD17, R1 after 5 strobes; a command pulse while busy must be ignored
    issue(6'd17, 32'h0000_0900, 2'd1);
    run_tx(line, dir_hi);
    strobe(1'b1);
    check_eq("cmd17_release", o_sd_cmd_dir, 1'b0);
    i_cmd_index = 6'd0; i_rsp_type = 2'd0; i_cmd_stb = 1'b1;
    idle_cycle();
    i_cmd_stb = 1'b0;
    repeat (4) strobe(1'b1);
    send_frame({2'b00, 6'd17, 32'h0000_0900, 7'h33, 1'b1}, 48);
    check_rsp("cmd17", 128'h11_0000_0900, 1'b0, 1'b0, 1'b0);
    check_gap("cmd17_ncc");

    // Same, with an argument bit flipped in the response
    issue(6'd17, 32'h0000_0900, 2'd1);
    run_tx(line, dir_hi);
    repeat (5) strobe(1'b1);
    send_frame({2'b00, 6'd17, 32'h0000_0901, 7'h33, 1'b1}, 48);
    check_rsp("cmd17_bad", 128'h11_0000_0901, CRC_ON, 1'b0, 1'b0);
    check_gap("cmd17_bad_ncc");

    // Timeout: line held high
    issue(6'd17, 32'h0000_0900, 2'd1);
    run_tx(line, dir_hi);
    strobe(1'b1);
    repeat (TMO - 1) strobe(1'b1);
    check_eq("tmo_early", o_timeout, 1'b0);
    check_eq("tmo_early_stb", o_rsp_stb, 1'b0);
    strobe(1'b1);
    check_rsp("tmo", 128'h0, 1'b0, 1'b0, 1'b1);
    check_gap("tmo_ncc");
    check_eq("tmo_hold", o_timeout, 1'b1);

    // Start bit on the release strobe itself; also clears the held timeout
    issue(6'd13, 32'h0, 2'd1);
    check_eq("tmo_cleared", o_timeout, 1'b0);
    run_tx(line, dir_hi);
    hdr = {2'b00, 6'd13, 32'h0};
    f = {88'd0, hdr, crc7_ref({80'd0, hdr}, 40), 1'b1};
    strobe(1'b0);
    send_frame(f, 47);
    check_rsp("early", 128'h0D_0000_0000, 1'b0, 1'b0, 1'b0);
    check_gap("early_ncc");

    // R2 with a bad end bit
    issue(6'd2, 32'h0, 2'd2);
    run_tx(line, dir_hi);
    repeat (2) strobe(1'b1);
    body = 120'h1D_4144_4D53_4420_1000_0035_A1B2_C3D4;
    f = {2'b00, 6'h3F, body, crc7_ref(body, 120), 1'b0};
    send_frame(f, 136);
    check_rsp("r2", f[127:0], 1'b0, 1'b1, 1'b0);
    check_gap("r2_ncc");

    // R3 with all-ones CRC field
    issue(6'd41, 32'h40FF_8000, 2'd3);
    run_tx(line, dir_hi);
    repeat (3) strobe(1'b1);
    send_frame({2'b00, 6'h3F, 32'h80FF_8000, 7'h7F, 1'b1}, 48);
    check_rsp("r3", 128'h3F_80FF_8000, 1'b0, 1'b0, 1'b0);
    check_gap("r3_ncc");

    // Reset in the middle of TX
    issue(6'd0, 32'h0, 2'd0);
    repeat (20) strobe(1'b1);
    check_eq("mid_dir", o_sd_cmd_dir, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("mid_rst_dir", o_sd_cmd_dir, 1'b0);
    check_eq("mid_rst_out", o_sd_cmd_out, 1'b1);
    check_eq("mid_rst_busy", o_cmd_busy, 1'b0);
    check_eq("mid_rst_stb", o_rsp_stb, 1'b0);
    issue(6'd0, 32'h0, 2'd0);
    run_tx(line, dir_hi);
    check_eq("post_rst_line", line, 48'h40_0000_0000_95);
    strobe(1'b1);
    check_rsp("post_rst", 128'h0, 1'b0, 1'b0, 1'b0);
    check_gap("post_rst_ncc");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
